// File: rtl/multi_operand_accumulator.sv
// Push-button driven accumulator: debounced presses each enter one operand y,
// summing N operands before parking in DONE until clr or rst.
module multi_operand_accumulator #(
    parameter  int unsigned W   = 4,
    parameter  int unsigned N   = 5,
    parameter  int unsigned DEB = 4,
    localparam int unsigned SW  = W + $clog2(N),
    localparam int unsigned CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pb,
    input  logic          clr,
    input  logic [W-1:0]  y,
    output logic [SW-1:0] sum,
    output logic [CW-1:0] count,
    output logic          accept,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CNTW = (DEB > 1) ? $clog2(DEB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            s1;
    logic            s2;
    logic            pb_db;
    logic            pb_db_q;
    logic [CNTW-1:0] db_cnt;
    logic            take;
    logic [SW-1:0]   sum_n;
    logic [CW-1:0]   count_n;
    logic [CW-1:0]   count_inc;
    logic            accept_n;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pb;
            s2 <= s1;
        end
    end

    // Debounce: pb_db follows s2 only after DEB consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_db  <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == pb_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNTW'(DEB - 1)) begin
            pb_db  <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNTW'(1);
        end
    end

    // Registered rising-edge pulse of the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_db_q <= 1'b0;
            take    <= 1'b0;
        end else begin
            pb_db_q <= pb_db;
            take    <= pb_db & ~pb_db_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign count_inc = count + CW'(1);

    // Next state and next datapath values; clr outranks take
    always_comb begin
        state_n  = state;
        sum_n    = sum;
        count_n  = count;
        accept_n = 1'b0;
        if (clr) begin
            state_n = IDLE;
            sum_n   = '0;
            count_n = '0;
        end else if (take) begin
            case (state)
                IDLE: begin
                    sum_n    = SW'(y);
                    count_n  = CW'(1);
                    accept_n = 1'b1;
                    state_n  = (N == 1) ? DONE : ACCUM;
                end
                ACCUM: begin
                    sum_n    = sum + SW'(y);
                    count_n  = count_inc;
                    accept_n = 1'b1;
                    if (count_inc == CW'(N)) begin
                        state_n = DONE;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum    <= '0;
            count  <= '0;
            accept <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            sum    <= sum_n;
            count  <= count_n;
            accept <= accept_n;
            busy   <= (state_n == ACCUM);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench for multi_operand_accumulator with W=4, N=5, DEB=4.
module tb_multi_operand_accumulator;

    localparam int unsigned W   = 4;
    localparam int unsigned N   = 5;
    localparam int unsigned DEB = 4;
    localparam int unsigned SW  = 7;
    localparam int unsigned CW  = 3;

    logic          clk;
    logic          rst;
    logic          pb;
    logic          clr;
    logic [W-1:0]  y;
    logic [SW-1:0] sum;
    logic [CW-1:0] count;
    logic          accept;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    multi_operand_accumulator #(.W(W), .N(N), .DEB(DEB)) dut (
        .clk(clk), .rst(rst), .pb(pb), .clr(clr), .y(y),
        .sum(sum), .count(count), .accept(accept), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accept pulses away from the active edge
    always @(negedge clk) begin
        if (accept) acc_cnt <= acc_cnt + 1;
    end

    task automatic press(input logic [W-1:0] v, input int hold, input int rel);
        @(negedge clk);
        y  = v;
        pb = 1'b1;
        repeat (hold) @(negedge clk);
        pb = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sum !== 7'd0 || count !== 3'd0 || accept !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: sum=%0d count=%0d acc=%b busy=%b done=%b, required all 0",
                     sum, count, accept, busy, done);
        end
    endtask

    task automatic test_zeros();
        int a0;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) press(4'b0000, 12, 12);
        checks++;
        if (sum !== 7'd0 || count !== 3'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL zeros: sum=%0d count=%0d done=%b, required 0 5 1", sum, count, done);
        end
        checks++;
        if (acc_cnt - a0 !== 5) begin
            errors++;
            $display("FAIL zeros_accepts: got %0d, required 5", acc_cnt - a0);
        end
    endtask

    task automatic test_ones();
        do_clr();
        for (int i = 1; i <= 5; i++) begin
            press(4'b1111, 12, 12);
            checks++;
            if (count !== CW'(i) || busy !== (i < 5) || done !== (i == 5)) begin
                errors++;
                $display("FAIL ones_step%0d: count=%0d busy=%b done=%b, required %0d %b %b",
                         i, count, busy, done, i, (i < 5), (i == 5));
            end
        end
        checks++;
        if (sum !== 7'd75) begin
            errors++;
            $display("FAIL ones_sum: sum=%0d, required 75", sum);
        end
    endtask

    task automatic test_done_ignore();
        int a0;
        a0 = acc_cnt;
        press(4'b0011, 12, 12);
        checks++;
        if (sum !== 7'd75 || count !== 3'd5 || done !== 1'b1 || acc_cnt != a0) begin
            errors++;
            $display("FAIL done_ignore: sum=%0d count=%0d done=%b accepts=%0d, required 75 5 1 0",
                     sum, count, done, acc_cnt - a0);
        end
        do_clr();
        checks++;
        if (sum !== 7'd0 || count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clr: sum=%0d count=%0d busy=%b done=%b, required 0 0 0 0",
                     sum, count, busy, done);
        end
    endtask

    task automatic test_fives();
        int a0;
        do_clr();
        for (int i = 1; i <= 5; i++) begin
            a0 = acc_cnt;
            press(4'b0101, 12, 12);
            checks++;
            if (count !== CW'(i) || sum !== SW'(5 * i) || acc_cnt - a0 !== 1) begin
                errors++;
                $display("FAIL fives_step%0d: count=%0d sum=%0d accepts=%0d, required %0d %0d 1",
                         i, count, sum, acc_cnt - a0, i, 5 * i);
            end
        end
    endtask

    task automatic test_latency();
        do_clr();
        @(negedge clk);
        y  = 4'd2;
        pb = 1'b1;
        @(posedge clk);
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || accept !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: count=%0d acc=%b, required 0 0", count, accept);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd1 || sum !== 7'd2 || accept !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge: count=%0d sum=%0d acc=%b busy=%b, required 1 2 1 1",
                     count, sum, accept, busy);
        end
        @(negedge clk);
        checks++;
        if (accept !== 1'b0) begin
            errors++;
            $display("FAIL accept_pulse: acc=%b, required 0", accept);
        end
        pb = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_glitch();
        int a0;
        do_clr();
        a0 = acc_cnt;
        press(4'b0111, 3, 20);
        checks++;
        if (count !== 3'd0 || sum !== 7'd0 || acc_cnt != a0) begin
            errors++;
            $display("FAIL glitch: count=%0d sum=%0d accepts=%0d, required 0 0 0",
                     count, sum, acc_cnt - a0);
        end
        press(4'b0011, 40, 20);
        checks++;
        if (count !== 3'd1 || sum !== 7'd3 || acc_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL held: count=%0d sum=%0d accepts=%0d, required 1 3 1",
                     count, sum, acc_cnt - a0);
        end
    endtask

    task automatic test_clr_take();
        int a0;
        a0 = acc_cnt;
        @(negedge clk);
        y  = 4'd6;
        pb = 1'b1;
        @(posedge clk);
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (count !== 3'd0 || sum !== 7'd0 || busy !== 1'b0 || acc_cnt != a0) begin
            errors++;
            $display("FAIL clr_take: count=%0d sum=%0d busy=%b accepts=%0d, required 0 0 0 0",
                     count, sum, busy, acc_cnt - a0);
        end
        repeat (10) @(negedge clk);
        pb = 1'b0;
        repeat (12) @(negedge clk);
        press(4'd7, 12, 12);
        checks++;
        if (count !== 3'd1 || sum !== 7'd7) begin
            errors++;
            $display("FAIL after_clr_take: count=%0d sum=%0d, required 1 7", count, sum);
        end
    endtask

    task automatic test_rst_mid();
        do_clr();
        for (int i = 0; i < 3; i++) press(4'd9, 12, 12);
        checks++;
        if (sum !== 7'd27 || count !== 3'd3) begin
            errors++;
            $display("FAIL nines: sum=%0d count=%0d, required 27 3", sum, count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sum !== 7'd0 || count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: sum=%0d count=%0d busy=%b done=%b, required 0 0 0 0",
                     sum, count, busy, done);
        end
        y  = 4'd9;
        pb = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (count !== 3'd0 || accept !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: count=%0d acc=%b, required 0 0", count, accept);
        end
        pb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        press(4'd9, 12, 12);
        checks++;
        if (sum !== 7'd9 || count !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_rst: sum=%0d count=%0d busy=%b, required 9 1 1", sum, count, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        pb  = 1'b0;
        clr = 1'b0;
        y   = '0;
        test_reset();
        test_zeros();
        test_ones();
        test_done_ignore();
        test_fives();
        test_latency();
        test_glitch();
        test_clr_take();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_operand_accumulator.md
MULTI_OPERAND_ACCUMULATOR -- requirements
Module: multi_operand_accumulator

Interface
REQ-001 Parameter W, default 4: operand width in bits.
REQ-002 Parameter N, default 5: number of operands per sum, N >= 1.
REQ-003 Parameter DEB, default 4: debounce length in clock cycles, DEB >= 1.
REQ-004 Derived SW = W + clog2(N), the sum width; CW = clog2(N+1), the count width.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pb  input  1  raw push-button level, asynchronous to clk; pressing it enters one operand.
REQ-008 clr  input  1  synchronous clear of the accumulation, active-high.
REQ-009 y  input  W  unsigned operand, sampled only in the take cycle.
REQ-010 sum  output  SW  running unsigned sum of the accepted operands.
REQ-011 count  output  CW  number of operands accepted so far, 0..N.
REQ-012 accept  output  1  one-cycle pulse on the cycle after an operand is added.
REQ-013 busy  output  1  high in state ACCUM.
REQ-014 done  output  1  high in state DONE.

Function
REQ-015 pb shall pass through a two-flop synchroniser (s1, s2) before any other use.
REQ-016 pb_db shall take the value of s2 only after s2 differs from pb_db for DEB consecutive cycles; any shorter excursion shall reset the debounce counter and leave pb_db unchanged.
REQ-017 The internal take signal shall be a registered one-cycle pulse on each 0->1 transition of pb_db; a 1->0 transition shall produce no take.
REQ-018 FSM states shall be IDLE, ACCUM and DONE.
REQ-019 In IDLE, take shall load sum = zero-extended y and set count = 1, then go to ACCUM, or to DONE if N == 1.
REQ-020 In ACCUM, take shall set sum = sum + y and count = count + 1; when the new count equals N the FSM shall go to DONE.
REQ-021 In DONE, take shall be ignored: sum and count hold and accept stays low.
REQ-022 The addition shall never overflow, because N*(2^W-1) < 2^SW; no carry or overflow output exists.
REQ-023 clr in any state shall give IDLE, sum = 0 and count = 0 at the next edge.
REQ-024 When clr and take occur in the same cycle, clr shall win and the operand shall be discarded.
REQ-025 Latency: pb held high with s1 sampling 1 at edge k shall update sum and count at edge k+DEB+3, with accept high for the following cycle.
REQ-026 Holding pb high shall enter exactly one operand; a release longer than DEB cycles followed by a new press shall be needed for the next one.
REQ-027 sum, count, busy, done and accept shall all be registered outputs.

Reset
REQ-028 rst shall have priority over clr and take.
REQ-029 rst shall set the FSM to IDLE and clear sum, count, accept, s1, s2, pb_db, the debounce counter and the take register to 0 at the next edge.
REQ-030 rst asserted mid-accumulation shall discard the partial sum; no operand shall be entered while rst is high.

Verification (W=4, N=5, DEB=4)
REQ-031 rst, then five clean presses with y=4'b0000 -> sum=0, count=5, done=1, five accept pulses.
REQ-032 Five presses with y=4'b1111 -> sum=7'd75, done=1; busy=1 after presses 1 to 4.
REQ-033 Five presses with y=4'b0101 -> sum=7'd25; count steps 1,2,3,4,5 with one accept per press.
REQ-034 A pb glitch of 3 cycles and a held press lasting 40 cycles -> the glitch adds nothing and the held press adds exactly one operand.
REQ-035 A sixth press while in DONE -> sum stays 75; then clr -> sum=0, count=0, IDLE; clr coincident with take -> operand dropped.
REQ-036 rst after 3 presses of y=4'd9 (sum=27) -> sum=0, count=0, IDLE at the next edge; the next press gives sum=9.
